// File: rtl/pe_pkg.sv
// Shared PE definitions used by the activation register-file read arbiter
// and its callers.
//   ACT_ADDR_WIDTH / ACT_DATA_WIDTH : default activation address/word widths
//   comp_en_e                       : compute-path enable encoding; the caller
//                                     turns it into req_vld[0] with comp_req()
package pe_pkg;

    localparam int ACT_ADDR_WIDTH = 6;
    localparam int ACT_DATA_WIDTH = 16;

    typedef enum logic {
        COMP_EN_IDLE   = 1'b0,
        COMP_EN_ACTIVE = 1'b1
    } comp_en_e;

    function automatic logic comp_req(input comp_en_e en);
        return en != COMP_EN_IDLE;
    endfunction

endpackage

// File: rtl/act_rf_read_arbiter_if.sv
// Bundle of the requester handshake and register-file read-port signals.
//   req_vld / req_addr / req_rdy : per-requester request handshake
//   rsp_vld / rsp_data           : one-hot response strobe and shared data
//   rf_read_en / rf_read_addr    : register-file read command
//   rf_read_data                 : register-file data, one cycle after enable
// slave  : arbiter side
// master : requester / register-file side
interface act_rf_read_arbiter_if
    import pe_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = ACT_ADDR_WIDTH,
    parameter int DATA_WIDTH = ACT_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_rdy;
    logic [NUM_REQ-1:0]            rsp_vld;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rf_read_en;
    logic [ADDR_WIDTH-1:0]         rf_read_addr;
    logic [DATA_WIDTH-1:0]         rf_read_data;

    modport slave (
        input  req_vld, req_addr, rf_read_data,
        output req_rdy, rsp_vld, rsp_data, rf_read_en, rf_read_addr
    );

    modport master (
        output req_vld, req_addr, rf_read_data,
        input  req_rdy, rsp_vld, rsp_data, rf_read_en, rf_read_addr
    );
endinterface

// File: rtl/prio_onehot_pick.sv
// Lowest-index-first one-hot picker.
//   req_i : request vector
//   gnt_o : one-hot of the lowest set bit of req_i, zero when req_i is zero
module prio_onehot_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/act_rf_read_arbiter.sv
// Read-port arbiter for the PE activation register file. Grants one of
// NUM_REQ requesters per cycle (index 0 = compute path, highest priority),
// with an aging guard that forces a grant to any port i >= 1 denied for
// STARVE_LIMIT consecutive cycles. Read data is returned one cycle after
// the grant with a one-hot response strobe.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : request/response and register-file read port (slave side)
module act_rf_read_arbiter
    import pe_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = ACT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = ACT_DATA_WIDTH,
    parameter int STARVE_LIMIT = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    act_rf_read_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0]    force_cand;
    logic [NUM_REQ-1:0]    force_gnt;
    logic [NUM_REQ-1:0]    norm_gnt;
    logic [NUM_REQ-1:0]    gnt;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [NUM_REQ-1:0]    rsp_vld_d;
    logic [NUM_REQ-1:0]    rsp_vld_q;

    if (NUM_REQ > 1 && STARVE_LIMIT > 0) begin : g_starve
        localparam int CW = $clog2(STARVE_LIMIT + 1);
        localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

        logic [CW-1:0] starve_d [1:NUM_REQ-1];
        logic [CW-1:0] starve_q [1:NUM_REQ-1];

        always_comb begin
            force_cand = '0;
            for (int i = 1; i < NUM_REQ; i++) begin
                force_cand[i] = bus.req_vld[i] && (starve_q[i] == LIM);
                // Count only denied cycles of a live request; saturate so a
                // port that keeps losing to a lower forced index stays eligible.
                if (bus.req_vld[i] && !gnt[i]) begin
                    starve_d[i] = (starve_q[i] == LIM) ? starve_q[i] : starve_q[i] + CW'(1);
                end else begin
                    starve_d[i] = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 1; i < NUM_REQ; i++) begin
                if (!rst_n) begin
                    starve_q[i] <= '0;
                end else begin
                    starve_q[i] <= starve_d[i];
                end
            end
        end
    end else begin : g_no_starve
        assign force_cand = '0;
    end

    prio_onehot_pick #(.N(NUM_REQ)) u_pick_force (
        .req_i (force_cand),
        .gnt_o (force_gnt)
    );

    prio_onehot_pick #(.N(NUM_REQ)) u_pick_norm (
        .req_i (bus.req_vld),
        .gnt_o (norm_gnt)
    );

    always_comb begin
        if (!rst_n) begin
            gnt = '0;
        end else if (|force_gnt) begin
            gnt = force_gnt;
        end else begin
            gnt = norm_gnt;
        end
    end

    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign rsp_vld_d = bus.req_vld & gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld_q <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
        end
    end

    assign bus.req_rdy      = gnt;
    assign bus.rf_read_en   = |gnt;
    assign bus.rf_read_addr = gnt_addr;
    assign bus.rsp_vld      = rsp_vld_q;
    assign bus.rsp_data     = (|rsp_vld_q) ? bus.rf_read_data : '0;
endmodule

// File: tb/tb_act_rf_read_arbiter.sv
// Bench for act_rf_read_arbiter. Three instances run side by side:
//   0: NUM_REQ=2, STARVE_LIMIT=8
//   1: NUM_REQ=2, STARVE_LIMIT=0 (pure fixed priority)
//   2: NUM_REQ=4, STARVE_LIMIT=8
// A behavioural model predicts grants; expected responses are queued at
// grant time and popped when the response cycle arrives.
module tb_act_rf_read_arbiter;
    import pe_pkg::*;

    localparam int AW = 6;
    localparam int DW = 16;

    typedef struct packed {
        logic [3:0]    vld;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [3:0]    t_vld  [3];
    logic [AW-1:0] t_addr [3][4];
    logic [DW-1:0] t_rfd  [3];

    logic [3:0]    o_rdy  [3];
    logic [3:0]    o_rsp  [3];
    logic          o_en   [3];
    logic [AW-1:0] o_addr [3];
    logic [DW-1:0] o_data [3];

    act_rf_read_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
    act_rf_read_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();
    act_rf_read_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_c ();

    act_rf_read_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    act_rf_read_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    act_rf_read_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(8))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    assign if_a.req_vld      = t_vld[0][1:0];
    assign if_a.req_addr     = {t_addr[0][1], t_addr[0][0]};
    assign if_a.rf_read_data = t_rfd[0];
    assign if_b.req_vld      = t_vld[1][1:0];
    assign if_b.req_addr     = {t_addr[1][1], t_addr[1][0]};
    assign if_b.rf_read_data = t_rfd[1];
    assign if_c.req_vld      = t_vld[2];
    assign if_c.req_addr     = {t_addr[2][3], t_addr[2][2], t_addr[2][1], t_addr[2][0]};
    assign if_c.rf_read_data = t_rfd[2];

    assign o_rdy[0]  = {2'b00, if_a.req_rdy};
    assign o_rdy[1]  = {2'b00, if_b.req_rdy};
    assign o_rdy[2]  = if_c.req_rdy;
    assign o_rsp[0]  = {2'b00, if_a.rsp_vld};
    assign o_rsp[1]  = {2'b00, if_b.rsp_vld};
    assign o_rsp[2]  = if_c.rsp_vld;
    assign o_en[0]   = if_a.rf_read_en;
    assign o_en[1]   = if_b.rf_read_en;
    assign o_en[2]   = if_c.rf_read_en;
    assign o_addr[0] = if_a.rf_read_addr;
    assign o_addr[1] = if_b.rf_read_addr;
    assign o_addr[2] = if_c.rf_read_addr;
    assign o_data[0] = if_a.rsp_data;
    assign o_data[1] = if_b.rsp_data;
    assign o_data[2] = if_c.rsp_data;

    int n_chk  = 0;
    int n_pass = 0;

    int nreq [3] = '{2, 2, 4};
    int lim  [3] = '{8, 0, 8};
    int cnt  [3][4];

    rsp_t sb_q0 [$];
    rsp_t sb_q1 [$];
    rsp_t sb_q2 [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Register-file contents as a function of address.
    function automatic logic [DW-1:0] rf_fn(input logic [AW-1:0] a);
        logic [3:0] lo;
        lo = a[3:0];
        return {a, lo, 6'h2B} ^ 16'h5A5A;
    endfunction

    function automatic logic [3:0] model_gnt(input int k);
        if (!rst_n) return 4'b0000;
        if (lim[k] > 0) begin
            for (int i = 1; i < nreq[k]; i++) begin
                if (t_vld[k][i] && cnt[k][i] == lim[k]) return 4'(1) << i;
            end
        end
        for (int i = 0; i < nreq[k]; i++) begin
            if (t_vld[k][i]) return 4'(1) << i;
        end
        return 4'b0000;
    endfunction

    task automatic sb_push(input int k, input rsp_t r);
        case (k)
            0: sb_q0.push_back(r);
            1: sb_q1.push_back(r);
            default: sb_q2.push_back(r);
        endcase
    endtask

    task automatic sb_pop(input int k, output rsp_t r, output bit ok);
        ok = 1'b1;
        r  = '0;
        case (k)
            0: if (sb_q0.size() > 0) r = sb_q0.pop_front(); else ok = 1'b0;
            1: if (sb_q1.size() > 0) r = sb_q1.pop_front(); else ok = 1'b0;
            default: if (sb_q2.size() > 0) r = sb_q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // One clock cycle: check combinational grant outputs, queue the expected
    // response, advance the clock, update the model and RF, check responses.
    task automatic step();
        logic [3:0]    g      [3];
        logic          sav_en [3];
        logic [AW-1:0] sav_a  [3];
        logic [AW-1:0] ga;
        rsp_t          r;
        bit            ok;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            g[k] = model_gnt(k);
            ga   = '0;
            for (int i = 0; i < nreq[k]; i++) begin
                if (g[k][i]) ga = t_addr[k][i];
            end
            check_eq($sformatf("req_rdy[%0d]", k), 32'(o_rdy[k]), 32'(g[k]));
            check_eq($sformatf("rf_read_en[%0d]", k), 32'(o_en[k]), 32'(g[k] != 4'b0000));
            check_eq($sformatf("rf_read_addr[%0d]", k), 32'(o_addr[k]), 32'(ga));
            r.vld  = g[k];
            r.data = (g[k] != 4'b0000) ? rf_fn(ga) : '0;
            sb_push(k, r);
            sav_en[k] = o_en[k];
            sav_a[k]  = o_addr[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (sav_en[k]) t_rfd[k] = rf_fn(sav_a[k]);
            for (int i = 1; i < nreq[k]; i++) begin
                if (!rst_n || lim[k] == 0) begin
                    cnt[k][i] = 0;
                end else if (t_vld[k][i] && !g[k][i]) begin
                    if (cnt[k][i] < lim[k]) cnt[k][i] = cnt[k][i] + 1;
                end else begin
                    cnt[k][i] = 0;
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            sb_pop(k, r, ok);
            check_eq($sformatf("sb_nonempty[%0d]", k), 32'(ok), 32'd1);
            check_eq($sformatf("rsp_vld[%0d]", k), 32'(o_rsp[k]), 32'(r.vld));
            check_eq($sformatf("rsp_data[%0d]", k), 32'(o_data[k]), 32'(r.data));
        end
    endtask

    task automatic set_all(input logic [3:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        for (int k = 0; k < 3; k++) begin
            t_vld[k]     = v;
            t_addr[k][0] = a0;
            t_addr[k][1] = a1;
            t_addr[k][2] = a2;
            t_addr[k][3] = a3;
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t_rfd[k] = 16'hBEEF;
            for (int i = 0; i < 4; i++) cnt[k][i] = 0;
        end
        set_all(4'b0000, '0, '0, '0, '0);
        @(posedge clk);
        #1;

        // Reset held with requests present: grant outputs forced low.
        set_all(4'b1111, 6'h01, 6'h02, 6'h03, 6'h04);
        run(2);

        // Idle: nothing granted, response data masked despite nonzero RF data.
        rst_n = 1'b1;
        set_all(4'b0000, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
        run(3);

        // Single request on port 1, then idle.
        set_all(4'b0010, 6'h00, 6'h15, 6'h00, 6'h00);
        run(1);
        set_all(4'b0000, 6'h00, 6'h15, 6'h00, 6'h00);
        run(2);

        // Continuous contention: port 1 forced on its 9th cycle when aging
        // is on; never granted when aging is off. Instance 2 also has ports
        // 2 and 3 saturating together.
        set_all(4'b1111, 6'h03, 6'h2A, 6'h11, 6'h22);
        t_vld[2] = 4'b1101;
        run(24);

        // Grant, then reset in the following cycle drops nothing visible late.
        set_all(4'b0010, 6'h00, 6'h07, 6'h00, 6'h00);
        run(1);
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;

        // After release, counters start again from zero.
        set_all(4'b1111, 6'h05, 6'h06, 6'h07, 6'h08);
        run(12);

        // Randomised traffic with changing addresses and occasional reset.
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 3; k++) begin
                t_vld[k] = 4'(~($urandom & $urandom));
                for (int i = 0; i < 4; i++) t_addr[k][i] = AW'($urandom);
            end
            rst_n = ($urandom_range(0, 59) != 0);
            step();
        end
        rst_n = 1'b1;
        set_all(4'b0000, '0, '0, '0, '0);
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/act_rf_read_arbiter.md
# act_rf_read_arbiter

Parametrised read-port arbiter for the PE activation register file. It generalises the fixed two-source read mux (compute-ADD vs. network-interface read) to NUM_REQ requesters with a valid/ready handshake and a starvation guard. It also returns read data to the granting requester with the register file's one-cycle read latency. It sits between the PE datapath/NI read clients and the single read port of the output-activation register file.

## Interface
- NUM_REQ, 2, number of read requesters; index 0 is the compute (ADD) path, highest priority; must be >= 1
- ADDR_WIDTH, 6, activation address width (PE activation count bus)
- DATA_WIDTH, 16, activation word width
- STARVE_LIMIT, 8, consecutive denied cycles before a forced grant; 0 disables aging (pure fixed priority)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset; synchronous and active-low
- req_vld  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_rdy  out  NUM_REQ  one-hot grant; request i accepted in the cycle req_vld[i] && req_rdy[i]
- rf_read_en  out  1  register-file read enable
- rf_read_addr  out  ADDR_WIDTH  register-file read address
- rf_read_data  in  DATA_WIDTH  register-file data, valid one cycle after rf_read_en
- rsp_vld  out  NUM_REQ  one-hot response strobe, one cycle after the matching grant
- rsp_data  out  DATA_WIDTH  response data, shared by all requesters, qualified by rsp_vld

## Operation
- Each cycle, at most one grant.
- Forced grant: a requester i >= 1 with starve_cnt[i] == STARVE_LIMIT and req_vld[i] wins. Among several, the lowest such index wins. Port 0 is stalled (req_rdy[0]=0) that cycle.
- Otherwise fixed priority: the lowest index with req_vld wins.
- req_rdy, rf_read_en and rf_read_addr are combinational from req_vld, req_addr and the starve counters. rf_read_addr = granted address; 0 when no grant.
- Starve counter per port i >= 1, width $clog2(STARVE_LIMIT+1):
  - increments, saturating at STARVE_LIMIT, when req_vld[i] && !req_rdy[i];
  - clears when granted or when req_vld[i] is low.
- Port 0 has no counter.
- If STARVE_LIMIT == 0, counters are not generated and forced grants never occur.
- If NUM_REQ == 1, req_rdy[0] = req_vld[0] and no counters are generated.
- Response stage: rsp_vld_q <= req_vld & req_rdy (registered one-hot). rsp_vld = rsp_vld_q. rsp_data = rf_read_data when |rsp_vld_q, else 0.
- Requesters may hold or change req_addr freely; only the accepted cycle's address is used. No request buffering: a denied requester must keep req_vld high to retry.

## Timing
- Grant latency 0 (same-cycle req_rdy). Data latency 1: rsp_vld[i] is high in cycle t+1 for a grant in cycle t.
- Back-to-back grants to any mix of ports every cycle; throughput is 1 read/cycle.
- While rst_n is low (sampled at the edge):
  - combinational outputs req_rdy, rf_read_en and rf_read_addr are forced to 0;
  - on the edge, rsp_vld_q and all starve counters clear.
- Reset asserted in the cycle after a grant drops that response: rsp_vld = 0 after the edge.
- Reset values: req_rdy=0, rf_read_en=0, rf_read_addr=0, rsp_vld=0, rsp_data=0, counters=0.
- Simultaneous requests from all ports: the port-0 streak is broken after exactly STARVE_LIMIT denials of the starved port. Its grant happens in the (STARVE_LIMIT+1)-th cycle of its request.

## Structure
- Shared package pe_pkg holds ACT_ADDR_WIDTH and ACT_DATA_WIDTH defaults and the COMP_EN idle encoding used by the caller to build req_vld[0].
- One sub-module: prio_onehot_pick (parameter N; input vector -> lowest-index one-hot). It is instantiated twice: once for the forced-candidate vector, once for the normal request vector. The arbiter selects the forced result when it is non-zero.

## Test plan
- NUM_REQ=2, STARVE_LIMIT=8, only req_vld[1]=1, addr 0x15 -> req_rdy=2'b10, rf_read_en=1, rf_read_addr=0x15. Next cycle: rsp_vld=2'b10, rsp_data=rf_read_data.
- Both ports request continuously, addrs 0x03/0x2A -> port 0 granted cycles 0–7. Cycle 8: req_rdy=2'b10, rf_read_addr=0x2A. Cycle 9: port 0 again, counter reads 0.
- STARVE_LIMIT=0, both requesting for 20 cycles -> port 1 never granted; rsp_vld always 2'b01 from cycle 1.
- NUM_REQ=4, ports 2 and 3 both saturated -> forced grant goes to port 2, then to port 3 after it reaches the limit. No cycle has two grants.
- Grant in cycle t, rst_n=0 in cycle t+1 -> rsp_vld=0 at t+1 after the edge. Outputs stay 0 while reset is held; all counters are 0 after release.
- No requests -> rf_read_en=0, rf_read_addr=0, rsp_vld=0, rsp_data=0 regardless of rf_read_data.
